// File: rtl/cs_scan_ctrl.sv
`timescale 1ns/1ps
// Colour-sensor scan scheduler: round-robin grant between two requesters,
// then green/red/blue counting windows, a max-count colour decision and a done pulse.
module cs_scan_ctrl #(
  parameter int unsigned WINDOW_CYC = 500,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MIN_CNT    = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       cfg_scale,
  input  logic             cs_out,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       scale,
  output logic [1:0]       filter,
  output logic             done,
  output logic [1:0]       color,
  output logic [CNT_W-1:0] red_freq,
  output logic [CNT_W-1:0] green_freq,
  output logic [CNT_W-1:0] blue_freq
);

  localparam int unsigned TMR_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [1:0] F_RED   = 2'd0;
  localparam logic [1:0] F_BLUE  = 2'd1;
  localparam logic [1:0] F_CLEAR = 2'd2;
  localparam logic [1:0] F_GREEN = 2'd3;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_RED   = 2'd1;
  localparam logic [1:0] C_GREEN = 2'd2;
  localparam logic [1:0] C_BLUE  = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    SETTLE_G,
    COUNT_G,
    SETTLE_R,
    COUNT_R,
    SETTLE_B,
    COUNT_B,
    DECIDE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] g_cap_q, g_cap_d;
  logic [CNT_W-1:0] r_cap_q, r_cap_d;
  logic [CNT_W-1:0] b_cap_q, b_cap_d;
  logic [CNT_W-1:0] red_freq_q, red_freq_d;
  logic [CNT_W-1:0] green_freq_q, green_freq_d;
  logic [CNT_W-1:0] blue_freq_q, blue_freq_d;
  logic [1:0]       color_q, color_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [1:0]       scale_q, scale_d;
  logic [1:0]       filter_q, filter_d;
  logic             done_q, done_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       cs_sync_q, cs_sync_d;
  logic             cs_prev_q, cs_prev_d;

  logic             rise;
  logic             in_count;
  logic             settle_end;
  logic             window_end;
  logic             pick;
  logic [CNT_W-1:0] cnt_live;
  logic [CNT_W-1:0] win_cnt;
  logic [1:0]       dec_color;

  assign rise       = cs_sync_q[1] & ~cs_prev_q;
  assign in_count   = (state_q == COUNT_G) || (state_q == COUNT_R) || (state_q == COUNT_B);
  assign settle_end = (tmr_q == TMR_W'(SETTLE_CYC - 1));
  assign window_end = (tmr_q == TMR_W'(WINDOW_CYC - 1));
  // ptr_q=0 favours req[0]; a lone request is granted regardless of the pointer
  assign pick       = (req == 2'b11) ? ptr_q : req[1];

  // Saturating pulse count including this cycle's edge, so the capture on the
  // last window cycle sees the final value.
  always_comb begin
    cnt_live = cnt_q;
    if (in_count && rise && (cnt_q != '1)) begin
      cnt_live = cnt_q + CNT_W'(1);
    end
  end

  // Tie priority red > green > blue falls out of the >= ordering.
  always_comb begin
    win_cnt   = b_cap_q;
    dec_color = C_BLUE;
    if ((r_cap_q >= g_cap_q) && (r_cap_q >= b_cap_q)) begin
      win_cnt   = r_cap_q;
      dec_color = C_RED;
    end else if (g_cap_q >= b_cap_q) begin
      win_cnt   = g_cap_q;
      dec_color = C_GREEN;
    end
    if (win_cnt < CNT_W'(MIN_CNT)) begin
      dec_color = C_NONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q + TMR_W'(1);
    cnt_d        = cnt_q;
    g_cap_d      = g_cap_q;
    r_cap_d      = r_cap_q;
    b_cap_d      = b_cap_q;
    red_freq_d   = red_freq_q;
    green_freq_d = green_freq_q;
    blue_freq_d  = blue_freq_q;
    color_d      = color_q;
    gnt_d        = gnt_q;
    busy_d       = busy_q;
    scale_d      = scale_q;
    filter_d     = filter_q;
    done_d       = 1'b0;
    ptr_d        = ptr_q;
    cs_sync_d    = {cs_sync_q[0], cs_out};
    cs_prev_d    = cs_sync_q[1];

    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (|req) begin
          gnt_d    = pick ? 2'b10 : 2'b01;
          ptr_d    = ~pick;
          busy_d   = 1'b1;
          scale_d  = cfg_scale;
          filter_d = F_GREEN;
          cnt_d    = '0;
          state_d  = SETTLE_G;
        end
      end
      SETTLE_G: begin
        if (settle_end) begin
          tmr_d   = '0;
          state_d = COUNT_G;
        end
      end
      COUNT_G: begin
        cnt_d = cnt_live;
        if (window_end) begin
          g_cap_d  = cnt_live;
          cnt_d    = '0;
          tmr_d    = '0;
          filter_d = F_RED;
          state_d  = SETTLE_R;
        end
      end
      SETTLE_R: begin
        if (settle_end) begin
          tmr_d   = '0;
          state_d = COUNT_R;
        end
      end
      COUNT_R: begin
        cnt_d = cnt_live;
        if (window_end) begin
          r_cap_d  = cnt_live;
          cnt_d    = '0;
          tmr_d    = '0;
          filter_d = F_BLUE;
          state_d  = SETTLE_B;
        end
      end
      SETTLE_B: begin
        if (settle_end) begin
          tmr_d   = '0;
          state_d = COUNT_B;
        end
      end
      COUNT_B: begin
        cnt_d = cnt_live;
        if (window_end) begin
          b_cap_d  = cnt_live;
          cnt_d    = '0;
          tmr_d    = '0;
          filter_d = F_CLEAR;
          state_d  = DECIDE;
        end
      end
      DECIDE: begin
        color_d      = dec_color;
        red_freq_d   = r_cap_q;
        green_freq_d = g_cap_q;
        blue_freq_d  = b_cap_q;
        done_d       = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      cnt_q        <= '0;
      g_cap_q      <= '0;
      r_cap_q      <= '0;
      b_cap_q      <= '0;
      red_freq_q   <= '0;
      green_freq_q <= '0;
      blue_freq_q  <= '0;
      color_q      <= C_NONE;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      scale_q      <= '0;
      filter_q     <= F_CLEAR;
      done_q       <= 1'b0;
      ptr_q        <= 1'b0;
      cs_sync_q    <= '0;
      cs_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      g_cap_q      <= g_cap_d;
      r_cap_q      <= r_cap_d;
      b_cap_q      <= b_cap_d;
      red_freq_q   <= red_freq_d;
      green_freq_q <= green_freq_d;
      blue_freq_q  <= blue_freq_d;
      color_q      <= color_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      scale_q      <= scale_d;
      filter_q     <= filter_d;
      done_q       <= done_d;
      ptr_q        <= ptr_d;
      cs_sync_q    <= cs_sync_d;
      cs_prev_q    <= cs_prev_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign scale      = scale_q;
  assign filter     = filter_q;
  assign done       = done_q;
  assign color      = color_q;
  assign red_freq   = red_freq_q;
  assign green_freq = green_freq_q;
  assign blue_freq  = blue_freq_q;

endmodule

// File: tb/tb_cs_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for cs_scan_ctrl: a sensor model whose pulse period follows the
// selected filter, with hand-computed counts, colours, grants and latency.
module tb_cs_scan_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int          LAT   = 1507;  // 3*(2+500)+1 cycles from grant edge to done

  logic             clk_1MHz = 1'b0;
  logic             rst_n    = 1'b1;
  logic [1:0]       req      = 2'b00;
  logic [1:0]       cfg_scale = 2'b00;
  logic             cs_out   = 1'b0;
  logic [1:0]       gnt;
  logic             busy;
  logic [1:0]       scale;
  logic [1:0]       filter;
  logic             done;
  logic [1:0]       color;
  logic [CNT_W-1:0] red_freq;
  logic [CNT_W-1:0] green_freq;
  logic [CNT_W-1:0] blue_freq;

  int total = 0;
  int bad   = 0;
  int per_g = 0;
  int per_r = 0;
  int per_b = 0;

  cs_scan_ctrl #(
    .WINDOW_CYC(500),
    .SETTLE_CYC(2),
    .MIN_CNT(16),
    .CNT_W(CNT_W)
  ) dut (
    .clk_1MHz(clk_1MHz),
    .rst_n(rst_n),
    .req(req),
    .cfg_scale(cfg_scale),
    .cs_out(cs_out),
    .gnt(gnt),
    .busy(busy),
    .scale(scale),
    .filter(filter),
    .done(done),
    .color(color),
    .red_freq(red_freq),
    .green_freq(green_freq),
    .blue_freq(blue_freq)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  // Sensor: half-us steps offset from the clock; phase restarts low on each filter change.
  initial begin
    logic [1:0] last_f;
    int ph;
    int p;
    last_f = 2'd2;
    ph = 0;
    #250;
    forever begin
      if (filter !== last_f) begin
        ph = 0;
        last_f = filter;
      end else begin
        ph++;
      end
      case (last_f)
        2'd3:    p = per_g;
        2'd0:    p = per_r;
        2'd1:    p = per_b;
        default: p = 0;
      endcase
      cs_out = (p != 0) && ((ph % (2 * p)) >= p);
      #500;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input logic [31:0] lo, input logic [31:0] hi);
    total++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Samples each falling edge after the grant cycle until done or the cycle budget.
  task automatic scan(input int drop_at, input int stop_at, output int cyc,
                      output logic [7:0] fseq, output int nf, output logic both,
                      output logic got);
    logic [1:0] lf;
    cyc = 0; fseq = '0; nf = 0; both = 1'b0; got = 1'b0; lf = filter;
    while (!got && (cyc < stop_at)) begin
      @(negedge clk_1MHz);
      cyc++;
      if (cyc == drop_at) req = 2'b00;
      if (gnt === 2'b11) both = 1'b1;
      if (filter !== lf) begin
        if (nf < 4) fseq = {fseq[5:0], filter};
        nf++;
        lf = filter;
      end
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic one_scan(input string tag, input logic [1:0] r, input logic [1:0] exp_gnt,
                          input logic [1:0] sc, input int drop_at);
    int cyc, nf;
    logic [7:0] fs;
    logic both, got;
    @(negedge clk_1MHz);
    req = r;
    cfg_scale = sc;
    @(negedge clk_1MHz);
    chk({tag, "_gnt"}, gnt, exp_gnt);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_filt0"}, filter, 2'd3);
    cfg_scale = ~sc;
    scan(drop_at, 3000, cyc, fs, nf, both, got);
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_lat"}, cyc, LAT);
    chk({tag, "_fseq"}, {nf[7:0], fs}, {8'd3, 8'h06});
    chk({tag, "_onehot"}, both, 1'b0);
    chk({tag, "_gnt_done"}, gnt, exp_gnt);
    chk({tag, "_scale"}, scale, sc);
    req = 2'b00;
    @(negedge clk_1MHz);
    chk({tag, "_done_1cyc"}, done, 1'b0);
    chk({tag, "_idle"}, {gnt, busy}, 3'b000);
  endtask

  task automatic chk_res(input string tag, input int r, input int g, input int b,
                         input logic [1:0] c);
    chk_rng({tag, "_red"}, red_freq, r - 1, r + 1);
    chk_rng({tag, "_green"}, green_freq, g - 1, g + 1);
    chk_rng({tag, "_blue"}, blue_freq, b - 1, b + 1);
    chk({tag, "_color"}, color, c);
  endtask

  task automatic do_reset();
    @(negedge clk_1MHz);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc, nf;
    logic [7:0] fs;
    logic both, got, saw_done;

    // Reset values
    #100 rst_n = 1'b0;
    #1;
    chk("rst_ctl", {gnt, busy, done}, 4'b0000);
    chk("rst_filter", filter, 2'd2);
    chk("rst_scale", scale, 2'd0);
    chk("rst_res", {color, red_freq, green_freq, blue_freq}, '0);
    repeat (3) @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);
    chk("idle_after_rst", {gnt, busy, done, filter}, 6'b000010);

    // 1: basic scan, green wins
    per_g = 4; per_r = 8; per_b = 10;
    one_scan("t1", 2'b01, 2'b01, 2'd2, -1);
    chk_res("t1", 62, 125, 50, 2'd2);
    @(negedge clk_1MHz);
    chk("t1_hold_color", color, 2'd2);

    // 2: both requesting; requester 0 first, then 1 after exactly one idle cycle
    do_reset();
    @(negedge clk_1MHz);
    req = 2'b11;
    cfg_scale = 2'd1;
    @(negedge clk_1MHz);
    chk("t2_gnt_a", gnt, 2'b01);
    scan(-1, 3000, cyc, fs, nf, both, got);
    chk("t2_done_a", got, 1'b1);
    chk("t2_onehot_a", both, 1'b0);
    req = 2'b10;
    @(negedge clk_1MHz);
    chk("t2_gap", {gnt, busy}, 3'b000);
    @(negedge clk_1MHz);
    chk("t2_gnt_b", {gnt, busy}, 3'b101);
    scan(-1, 3000, cyc, fs, nf, both, got);
    chk("t2_done_b", got, 1'b1);
    chk("t2_lat_b", cyc, LAT);
    chk("t2_onehot_b", both, 1'b0);
    chk("t2_color_b", color, 2'd2);
    req = 2'b00;
    @(negedge clk_1MHz);

    // 3: red/green tie goes to red
    per_g = 6; per_r = 6; per_b = 20;
    one_scan("t3", 2'b01, 2'b01, 2'd3, -1);
    chk_res("t3", 83, 83, 25, 2'd1);

    // 4: dark sensor, then counts below and at the threshold
    per_g = 0; per_r = 0; per_b = 0;
    one_scan("t4a", 2'b01, 2'b01, 2'd0, -1);
    chk("t4a_freqs", {red_freq, green_freq, blue_freq}, '0);
    chk("t4a_color", color, 2'd0);
    per_g = 50; per_r = 50; per_b = 50;
    one_scan("t4b", 2'b10, 2'b10, 2'd1, -1);
    chk_res("t4b", 10, 10, 10, 2'd0);
    per_g = 31; per_r = 0; per_b = 0;
    one_scan("t4c", 2'b01, 2'b01, 2'd1, -1);
    chk("t4c_green_min", green_freq, 16);
    chk("t4c_color", color, 2'd2);
    per_g = 10; per_r = 10; per_b = 4;
    one_scan("t4d", 2'b01, 2'b01, 2'd2, -1);
    chk_res("t4d", 50, 50, 125, 2'd3);
    per_g = 6; per_r = 20; per_b = 6;
    one_scan("t4e", 2'b10, 2'b10, 2'd2, -1);
    chk_res("t4e", 25, 83, 83, 2'd2);

    // 5: request dropped mid COUNT_R; scan still completes
    per_g = 4; per_r = 8; per_b = 10;
    one_scan("t5a", 2'b01, 2'b01, 2'd2, 700);
    chk_res("t5a", 62, 125, 50, 2'd2);
    one_scan("t5b", 2'b10, 2'b10, 2'd1, -1);

    // 6: reset during COUNT_B
    @(negedge clk_1MHz);
    req = 2'b01;
    @(negedge clk_1MHz);
    chk("t6_gnt", gnt, 2'b01);
    scan(-1, 1200, cyc, fs, nf, both, got);
    chk("t6_no_done_yet", got, 1'b0);
    chk("t6_in_count_b", filter, 2'd1);
    #100 rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {gnt, busy, done}, 4'b0000);
    chk("t6_rst_filter", filter, 2'd2);
    chk("t6_rst_res", {color, red_freq, green_freq, blue_freq}, '0);
    req = 2'b00;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk_1MHz);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    chk("t6_no_done", saw_done, 1'b0);
    one_scan("t6r", 2'b01, 2'b01, 2'd2, -1);
    chk_res("t6r", 62, 125, 50, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
